mips_mc_ctrl: RTL

- Multi-cycle control FSM for the MIPS core. It sequences one shared memory port, the ALU, the register file and the PC/IR/ALUOut/MDR registers across FETCH/DECODE/EXEC/MEM/WB states.
- It replaces the single-cycle decoder in the multi-cycle build. Memory accesses use a req/ready handshake with an optional watchdog.
- It is purely a controller: all select and strobe outputs drive the existing datapath muxes and registers.

---
 rtl/mips_mc_pkg.sv | 85 ++++++++
 rtl/mips_mc_decode.sv | 70 +++++++
 rtl/mips_mc_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS controller.
package mips_mc_pkg;

  // Controller states; the numeric values appear on the debug state port.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEMRD  = 4'd3,
    S_LWWB   = 4'd4,
    S_MEMWR  = 4'd5,
    S_ALU    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9
  } state_t;

  // Primary opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes (IR[5:0]).
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RT    = 2'd0,
    SRCB_FOUR  = 2'd1,
    SRCB_IMM   = 2'd2,
    SRCB_BROFF = 2'd3
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RS     = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } reg_dst_t;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2
  } mem_to_reg_t;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'd0,
    EXT_SIGN = 2'd1,
    EXT_HI   = 2'd2
  } ext_op_t;

  // Instruction class chosen in DECODE.
  typedef enum logic [2:0] {
    CLS_ILL = 3'd0,
    CLS_MEM = 3'd1,
    CLS_ALU = 3'd2,
    CLS_BR  = 3'd3,
    CLS_JMP = 3'd4
  } iclass_t;

  // States that hold a memory request open and can therefore stall.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational opcode/funct decode into an instruction class plus ALU selects.
module mips_mc_decode
  import mips_mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       is_load,
  output logic       is_rtype,
  output logic       is_jal,
  output logic       is_jr,
  output alu_src_b_t alu_b,
  output ext_op_t    ext,
  output alu_op_t    aop
);

  // Classify the instruction and pick its execute-stage ALU configuration.
  always_comb begin
    iclass   = CLS_ILL;
    is_load  = 1'b0;
    is_rtype = 1'b0;
    is_jal   = 1'b0;
    is_jr    = 1'b0;
    alu_b    = SRCB_RT;
    ext      = EXT_ZERO;
    aop      = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        is_rtype = 1'b1;
        case (funct)
          FN_ADDU: iclass = CLS_ALU;
          FN_SUBU: begin
            iclass = CLS_ALU;
            aop    = ALU_SUB;
          end
          FN_JR: begin
            iclass = CLS_JMP;
            is_jr  = 1'b1;
          end
          default: iclass = CLS_ILL;
        endcase
      end
      OP_ORI: begin
        iclass = CLS_ALU;
        alu_b  = SRCB_IMM;
        ext    = EXT_ZERO;
        aop    = ALU_OR;
      end
      OP_LUI: begin
        iclass = CLS_ALU;
        alu_b  = SRCB_IMM;
        ext    = EXT_HI;
        aop    = ALU_ADD;
      end
      OP_LW: begin
        iclass  = CLS_MEM;
        is_load = 1'b1;
      end
      OP_SW:  iclass = CLS_MEM;
      OP_BEQ: iclass = CLS_BR;
      OP_J:   iclass = CLS_JMP;
      OP_JAL: begin
        iclass = CLS_JMP;
        is_jal = 1'b1;
      end
      default: iclass = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences memory, ALU, register file and PC/IR.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       rf_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic       retire,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam bit              WD_EN    = (WAIT_LIMIT != 0);
  localparam logic [CNT_W-1:0] LIMIT_M1 = WD_EN ? CNT_W'(WAIT_LIMIT - 1) : '0;

  state_t           cur, nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             expire;

  iclass_t    dec_class;
  logic       dec_load, dec_rtype, dec_jal, dec_jr;
  alu_src_b_t dec_src_b;
  ext_op_t    dec_ext;
  alu_op_t    dec_alu;

  mips_mc_decode u_dec (
    .opcode   (opcode),
    .funct    (funct),
    .iclass   (dec_class),
    .is_load  (dec_load),
    .is_rtype (dec_rtype),
    .is_jal   (dec_jal),
    .is_jr    (dec_jr),
    .alu_b    (dec_src_b),
    .ext      (dec_ext),
    .aop      (dec_alu)
  );

  assign state   = cur;
  assign waiting = is_wait_state(cur) && !mem_ready;
  // mem_ready takes priority: expiry is only possible on a non-ready cycle.
  assign expire  = WD_EN && waiting && (wait_cnt == LIMIT_M1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // Watchdog counter: counts stalled cycles, clears on progress or expiry, saturates.
  always_ff @(posedge clk) begin
    if (reset)                  wait_cnt <= '0;
    else if (!waiting || expire) wait_cnt <= '0;
    else if (wait_cnt != '1)    wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Next-state and Moore output decode; reset forces every strobe and select low.
  always_comb begin
    nxt         = cur;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = '0;
    rf_we       = 1'b0;
    reg_dst     = '0;
    mem_to_reg  = '0;
    alu_src_a   = 1'b0;
    alu_src_b   = '0;
    ext_op      = '0;
    alu_op      = '0;
    retire      = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    if (!reset) begin
      case (cur)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
          if (mem_ready) begin
            ir_we  = 1'b1;
            pc_we  = 1'b1;
            pc_src = PC_ALU;
            nxt    = S_DECODE;
          end else if (expire) begin
            mem_timeout = 1'b1;
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_BROFF;
          ext_op    = EXT_SIGN;
          alu_op    = ALU_ADD;
          case (dec_class)
            CLS_MEM: nxt = S_ADDR;
            CLS_ALU: nxt = S_ALU;
            CLS_BR:  nxt = S_BR;
            CLS_JMP: nxt = S_JMP;
            default: begin
              illegal = 1'b1;
              nxt     = S_FETCH;
            end
          endcase
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          ext_op    = EXT_SIGN;
          alu_op    = ALU_ADD;
          nxt       = dec_load ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            nxt = S_LWWB;
          end else if (expire) begin
            mem_timeout = 1'b1;
            nxt         = S_FETCH;
          end
        end
        S_LWWB: begin
          rf_we      = 1'b1;
          reg_dst    = DST_RT;
          mem_to_reg = WB_MDR;
          retire     = 1'b1;
          nxt        = S_FETCH;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else if (expire) begin
            mem_timeout = 1'b1;
            nxt         = S_FETCH;
          end
        end
        S_ALU: begin
          alu_src_a = 1'b1;
          alu_src_b = dec_src_b;
          ext_op    = dec_ext;
          alu_op    = dec_alu;
          nxt       = S_ALUWB;
        end
        S_ALUWB: begin
          rf_we      = 1'b1;
          mem_to_reg = WB_ALUOUT;
          reg_dst    = dec_rtype ? DST_RD : DST_RT;
          retire     = 1'b1;
          nxt        = S_FETCH;
        end
        S_BR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_RT;
          alu_op    = ALU_SUB;
          pc_src    = PC_ALUOUT;
          pc_we     = zero;
          retire    = 1'b1;
          nxt       = S_FETCH;
        end
        S_JMP: begin
          pc_we  = 1'b1;
          retire = 1'b1;
          pc_src = dec_jr ? PC_RS : PC_JUMP;
          if (dec_jal) begin
            rf_we      = 1'b1;
            reg_dst    = DST_RA;
            mem_to_reg = WB_PC;
          end
          nxt = S_FETCH;
        end
        default: nxt = S_FETCH;
      endcase
    end
  end

endmodule
